// File: rtl/clock_divider_prog.sv
// clock_divider_prog: N_CH programmable clock dividers producing near-50% clock levels and
// period-start ticks; new divisors apply at the next period start.
module clock_divider_prog #(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                    clk_50,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [N_CH*WIDTH-1:0]   div_in,
    input  logic                    div_load,
    output logic [N_CH-1:0]         clk_out,
    output logic [N_CH-1:0]         tick,
    output logic                    load_busy
);
    logic [N_CH-1:0] pend_v;
    logic            load_busy_q;
    genvar c;
    for (c = 0; c < N_CH; c++) begin : g_ch
        logic [WIDTH-1:0] cnt_q, cnt_d, cur_q, cur_d, pdiv_q, pdiv_d;
        logic [WIDTH-1:0] sl, nd, half, cnt_inc;
        logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, act, last;
        assign sl      = div_in[c*WIDTH +: WIDTH];
        assign nd      = pend_q ? pdiv_q : cur_q;
        assign half    = (cur_q >> 1) + WIDTH'(cur_q[0]);
        assign cnt_inc = cnt_q + WIDTH'(1);
        assign last    = cnt_q == cur_q - WIDTH'(1);
        // Every running cycle has either cnt != 0 or (cycle 0) a high clock level
        assign act     = clk_q | (cnt_q != '0);
        always_comb begin
            cnt_d  = '0;
            cur_d  = cur_q;
            pdiv_d = pdiv_q;
            pend_d = pend_q;
            clk_d  = 1'b0;
            tick_d = 1'b0;
            if (!en || cur_q == '0) begin
                cur_d  = div_load ? sl : nd;
                pend_d = 1'b0;
            end else if (!act || last) begin
                cur_d  = nd;
                pend_d = div_load;
                pdiv_d = div_load ? sl : pdiv_q;
                clk_d  = nd != '0;
                tick_d = nd != '0;
            end else begin
                cnt_d  = cnt_inc;
                clk_d  = cnt_inc < half;
                pend_d = pend_q | div_load;
                pdiv_d = div_load ? sl : pdiv_q;
            end
        end
        always_ff @(posedge clk_50 or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                cur_q  <= WIDTH'(DEFAULT_DIV);
                pdiv_q <= '0;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                cur_q  <= cur_d;
                pdiv_q <= pdiv_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end
        assign clk_out[c] = clk_q;
        assign tick[c]    = tick_q;
        assign pend_v[c]  = pend_d;
    end
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) load_busy_q <= 1'b0;
        else        load_busy_q <= |pend_v;
    end
    assign load_busy = load_busy_q;
endmodule

// File: tb/tb_clock_divider_prog.sv
// tb_clock_divider_prog: directed and random stimulus checked against a period-position
// reference model of the programmable divider.
module tb_clock_divider_prog;
    localparam int N = 4, W = 16, DD = 2;
    logic clk_50 = 1'b0, rst_n = 1'b1, en = 1'b0, div_load = 1'b0;
    logic [N*W-1:0] div_in = '0;
    logic [N-1:0] clk_out, tick;
    logic load_busy;
    int n_chk = 0, n_err = 0;
    int pos[N], cur[N], pdiv[N], cfg[N];
    bit pend[N];

    clock_divider_prog #(.N_CH(N), .WIDTH(W), .DEFAULT_DIV(DD)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .en(en), .div_in(div_in), .div_load(div_load),
        .clk_out(clk_out), .tick(tick), .load_busy(load_busy));

    always #10 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pos = index of the current cycle inside the period, -1 when not in a period
    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            pos[i] = -1; cur[i] = DD; pend[i] = 0; pdiv[i] = 0; cfg[i] = DD;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            int s;
            s = int'(div_in[i*W +: W]);
            if (!en || cur[i] == 0) begin
                if (div_load) cur[i] = s;
                else if (pend[i]) cur[i] = pdiv[i];
                pend[i] = 0;
                pos[i] = -1;
            end else if (pos[i] < 0 || pos[i] == cur[i] - 1) begin
                if (pend[i]) cur[i] = pdiv[i];
                pend[i] = div_load;
                if (div_load) pdiv[i] = s;
                pos[i] = (cur[i] != 0) ? 0 : -1;
            end else begin
                pos[i]++;
                if (div_load) begin pend[i] = 1; pdiv[i] = s; end
            end
        end
    endtask

    function automatic logic [N-1:0] exp_clk();
        for (int i = 0; i < N; i++)
            exp_clk[i] = pos[i] >= 0 && pos[i] < (cur[i] + 1) / 2;
    endfunction

    function automatic logic [N-1:0] exp_tick();
        for (int i = 0; i < N; i++) exp_tick[i] = pos[i] == 0;
    endfunction

    function automatic logic exp_busy();
        exp_busy = 0;
        for (int i = 0; i < N; i++) exp_busy |= pend[i];
    endfunction

    // called just after a negedge; ends at the following negedge
    task automatic cyc(input logic e, input logic ld);
        en = e; div_load = ld;
        for (int i = 0; i < N; i++) div_in[i*W +: W] = cfg[i][W-1:0];
        @(posedge clk_50);
        model_step();
        #1;
        chk("clk_out", 32'(clk_out), 32'(exp_clk()));
        chk("tick", 32'(tick), 32'(exp_tick()));
        chk("load_busy", 32'(load_busy), 32'(exp_busy()));
        @(negedge clk_50);
    endtask

    task automatic load(input int ch, input int val);
        cfg[ch] = val;
        cyc(1, 1);
    endtask

    task automatic wait_start(input int ch);
        int k = 0;
        while (!(pos[ch] == 0 && !pend[ch]) && k < 40) begin cyc(1, 0); k++; end
        chk("wait_start", 32'(tick[ch]), 32'(1));
    endtask

    initial begin
        logic [4:0] pat, tpat;
        logic silent;
        int t0, t1, t2;
        model_reset();
        #1 rst_n = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_50);
            chk("rst_clk", 32'(clk_out), 32'(0));
            chk("rst_tick", 32'(tick), 32'(0));
            chk("rst_busy", 32'(load_busy), 32'(0));
        end
        rst_n = 1'b1;
        cyc(1, 0);
        chk("start_clk", 32'(clk_out), 32'hF);
        chk("start_tick", 32'(tick), 32'hF);
        cyc(1, 0);
        chk("d2_low", 32'(clk_out), 32'h0);
        cyc(1, 0);
        chk("d2_tick", 32'(tick), 32'hF);

        cfg[1] = 4;
        load(0, 5);
        wait_start(0);
        pat = '0; tpat = '0;
        for (int k = 4; k >= 0; k--) begin
            pat[k] = clk_out[0]; tpat[k] = tick[0];
            if (k > 0) cyc(1, 0);
        end
        chk("d5_clk", 32'(pat), 32'(5'b11100));
        chk("d5_tick", 32'(tpat), 32'(5'b10000));

        load(0, 6);
        wait_start(0);
        cyc(1, 0); cyc(1, 0);
        load(0, 3);
        chk("sw_busy", 32'(load_busy), 32'(1));
        chk("sw_c3", 32'(clk_out[0]), 32'(0));
        cyc(1, 0); cyc(1, 0);
        chk("sw_c5_tick", 32'(tick[0]), 32'(0));
        pat = '0;
        for (int k = 2; k >= 0; k--) begin
            cyc(1, 0);
            pat[k] = clk_out[0];
            if (k == 2) chk("sw_apply_tick", 32'(tick[0]), 32'(1));
        end
        chk("d3_clk", 32'(pat[2:0]), 32'(3'b110));

        load(0, 1);
        wait_start(0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0);
            chk("d1_level", 32'({clk_out[0], tick[0]}), 32'(2'b11));
        end
        load(0, 0);
        cyc(1, 0);
        chk("d0_off", 32'({clk_out[0], tick[0]}), 32'(0));
        cyc(1, 0); cyc(1, 0);
        chk("d0_stay", 32'({clk_out[0], tick[0]}), 32'(0));
        load(0, 3);
        chk("d0_load_off", 32'(clk_out[0]), 32'(0));
        cyc(1, 0);
        chk("d0_load_start", 32'(tick[0]), 32'(1));

        load(0, 8);
        wait_start(0);
        cyc(1, 0); cyc(1, 0); cyc(1, 0);
        cyc(0, 0);
        chk("en_drop_clk", 32'(clk_out), 32'h0);
        chk("en_drop_tick", 32'(tick), 32'h0);
        cyc(1, 0);
        chk("en_restart", 32'(tick), 32'hF);

        load(0, 5);
        chk("pend_busy", 32'(load_busy), 32'(1));
        #3 rst_n = 1'b0;
        #1;
        chk("async_clk", 32'(clk_out), 32'h0);
        chk("async_busy", 32'(load_busy), 32'(0));
        @(negedge clk_50);
        rst_n = 1'b1;
        model_reset();
        cyc(1, 0);
        chk("post_rst_hi", 32'(clk_out), 32'hF);
        cyc(1, 0);
        chk("post_rst_lo", 32'(clk_out), 32'h0);

        cfg[0] = 2; cfg[1] = 3; cfg[2] = 5; cfg[3] = 0;
        cyc(1, 1);
        load(2, 7);
        for (int k = 0; k < 10; k++) cyc(1, 0);
        silent = 0; t0 = 0; t1 = 0; t2 = 0;
        for (int k = 0; k < 42; k++) begin
            cyc(1, 0);
            silent |= clk_out[3] | tick[3];
            t0 += int'(tick[0]); t1 += int'(tick[1]); t2 += int'(tick[2]);
        end
        chk("ch3_silent", 32'(silent), 32'(0));
        chk("ch0_ticks", t0, 21);
        chk("ch1_ticks", t1, 14);
        chk("ch2_ticks", t2, 6);

        for (int k = 0; k < 600; k++) begin
            logic ld;
            ld = ($urandom % 8) == 0;
            if (ld) for (int i = 0; i < N; i++) cfg[i] = int'($urandom % 10);
            cyc(($urandom % 16) != 0, ld);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
